rob_commit: RTL and testbench

- Reorder buffer sitting between dispatch (IDU issue) and architectural writeback (WBU/regfile).
- Allocates a destination tag per dispatched instruction and absorbs out-of-order EXU results tagged by that value.
- Answers operand-readiness lookups for the issuing stage.
- Retires entries strictly in program order, one per cycle, and raises a pipeline redirect on a retired control-flow change.

---
 rtl/rob_commit.sv | 189 ++++++++++++++++++
 tb/tb_rob_commit.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Reorder buffer: allocates tags at dispatch, absorbs out-of-order results, retires in order.
// Optional macro ROB_WB_BYPASS_EN lets operand lookups see a same-cycle writeback.
module rob_commit #(
  parameter int ROB_SIZE = 8,
  parameter int XLEN     = 32,
  parameter int TW       = $clog2(ROB_SIZE) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            disp_valid,
  output logic            disp_ready,
  output logic [TW-1:0]   disp_tag,
  input  logic [4:0]      disp_rd,
  input  logic [XLEN-1:0] disp_pc,
  input  logic [31:0]     disp_inst,
  input  logic            disp_store,
  input  logic            wb_valid,
  input  logic [TW-1:0]   wb_dest,
  input  logic [XLEN-1:0] wb_result,
  input  logic [XLEN-1:0] wb_npc,
  input  logic            wb_pc_change,
  input  logic            wb_ebreak,
  input  logic [TW-1:0]   lk1_tag,
  input  logic [TW-1:0]   lk2_tag,
  output logic            lk1_ready,
  output logic            lk2_ready,
  output logic [XLEN-1:0] lk1_value,
  output logic [XLEN-1:0] lk2_value,
  output logic            cm_valid,
  output logic [4:0]      cm_rd,
  output logic [XLEN-1:0] cm_data,
  output logic [TW-1:0]   cm_tag,
  output logic [XLEN-1:0] cm_pc,
  output logic [31:0]     cm_inst,
  output logic            cm_store,
  output logic            cm_ebreak,
  output logic            flush_valid,
  output logic [XLEN-1:0] flush_npc,
  output logic            empty
);

  localparam int PW = $clog2(ROB_SIZE);
  localparam logic [TW-1:0] TAG_ONE  = TW'(1);
  localparam logic [TW-1:0] FULL_CNT = TW'(ROB_SIZE);

  logic [ROB_SIZE-1:0] valid_r, done_r, store_r, pc_change_r, ebreak_r;
  logic [4:0]          rd_r     [ROB_SIZE];
  logic [XLEN-1:0]     pc_r     [ROB_SIZE];
  logic [XLEN-1:0]     result_r [ROB_SIZE];
  logic [XLEN-1:0]     npc_r    [ROB_SIZE];
  logic [31:0]         inst_r   [ROB_SIZE];
  logic [PW-1:0]       head_r, tail_r;
  logic [TW-1:0]       count_r;

  logic          retire_s, flush_s, disp_fire_s, wb_fire_s;
  logic [PW-1:0] wb_idx_s, lk1_idx_s, lk2_idx_s;
  logic          byp1_s, byp2_s;

  function automatic logic tag_ok(input logic [TW-1:0] tag);
    return (tag != {TW{1'b0}}) && (tag <= FULL_CNT);
  endfunction

  // Tag t names entry t-1; the top tag bit only exists to keep 0 free for "no producer".
  function automatic logic [PW-1:0] tag_idx(input logic [TW-1:0] tag);
    return PW'(tag - TAG_ONE);
  endfunction

  function automatic logic [XLEN:0] lookup(
    input logic [TW-1:0]   tag,
    input logic            ent_valid,
    input logic            ent_done,
    input logic [XLEN-1:0] ent_result,
    input logic            byp,
    input logic [XLEN-1:0] byp_result
  );
    logic [XLEN:0] r;
    if (tag == {TW{1'b0}}) begin
      r = {1'b1, {XLEN{1'b0}}};
    end else if (!tag_ok(tag) || !ent_valid) begin
      r = {(XLEN+1){1'b0}};
    end else if (ent_done) begin
      r = {1'b1, ent_result};
    end else if (byp) begin
      r = {1'b1, byp_result};
    end else begin
      r = {(XLEN+1){1'b0}};
    end
    return r;
  endfunction

`ifdef ROB_WB_BYPASS_EN
  assign byp1_s = wb_valid && (wb_dest == lk1_tag);
  assign byp2_s = wb_valid && (wb_dest == lk2_tag);
`else
  assign byp1_s = 1'b0;
  assign byp2_s = 1'b0;
`endif

  // Handshake, retire/flush decode and writeback acceptance.
  always_comb begin
    retire_s    = valid_r[head_r] && done_r[head_r];
    flush_s     = retire_s && pc_change_r[head_r];
    disp_ready  = (count_r < FULL_CNT) && !flush_s;
    disp_tag    = {1'b0, tail_r} + TAG_ONE;
    disp_fire_s = disp_valid && disp_ready;
    empty       = (count_r == {TW{1'b0}});
    wb_idx_s    = tag_idx(wb_dest);
    wb_fire_s   = wb_valid && tag_ok(wb_dest) && valid_r[wb_idx_s] && !flush_s
                  && !(disp_fire_s && (wb_idx_s == tail_r));
  end

  // Operand readiness lookups for the issue stage.
  always_comb begin
    lk1_idx_s = tag_idx(lk1_tag);
    lk2_idx_s = tag_idx(lk2_tag);
    {lk1_ready, lk1_value} = lookup(lk1_tag, valid_r[lk1_idx_s], done_r[lk1_idx_s],
                                    result_r[lk1_idx_s], byp1_s, wb_result);
    {lk2_ready, lk2_value} = lookup(lk2_tag, valid_r[lk2_idx_s], done_r[lk2_idx_s],
                                    result_r[lk2_idx_s], byp2_s, wb_result);
  end

  // Entry state, pointers and registered retire/redirect outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r     <= {ROB_SIZE{1'b0}};
      done_r      <= {ROB_SIZE{1'b0}};
      head_r      <= {PW{1'b0}};
      tail_r      <= {PW{1'b0}};
      count_r     <= {TW{1'b0}};
      cm_valid    <= 1'b0;
      cm_rd       <= 5'd0;
      cm_data     <= {XLEN{1'b0}};
      cm_tag      <= {TW{1'b0}};
      cm_pc       <= {XLEN{1'b0}};
      cm_inst     <= 32'd0;
      cm_store    <= 1'b0;
      cm_ebreak   <= 1'b0;
      flush_valid <= 1'b0;
      flush_npc   <= {XLEN{1'b0}};
    end else begin
      cm_valid    <= 1'b0;
      cm_store    <= 1'b0;
      cm_ebreak   <= 1'b0;
      flush_valid <= 1'b0;
      if (disp_fire_s) begin
        valid_r[tail_r] <= 1'b1;
        done_r[tail_r]  <= 1'b0;
        rd_r[tail_r]    <= disp_rd;
        pc_r[tail_r]    <= disp_pc;
        inst_r[tail_r]  <= disp_inst;
        store_r[tail_r] <= disp_store;
        tail_r          <= tail_r + PW'(1);
      end
      if (wb_fire_s) begin
        done_r[wb_idx_s]      <= 1'b1;
        result_r[wb_idx_s]    <= wb_result;
        npc_r[wb_idx_s]       <= wb_npc;
        pc_change_r[wb_idx_s] <= wb_pc_change;
        ebreak_r[wb_idx_s]    <= wb_ebreak;
      end
      if (retire_s) begin
        cm_valid        <= 1'b1;
        cm_rd           <= rd_r[head_r];
        cm_data         <= result_r[head_r];
        cm_tag          <= {1'b0, head_r} + TAG_ONE;
        cm_pc           <= pc_r[head_r];
        cm_inst         <= inst_r[head_r];
        cm_store        <= store_r[head_r];
        cm_ebreak       <= ebreak_r[head_r];
        valid_r[head_r] <= 1'b0;
        done_r[head_r]  <= 1'b0;
        head_r          <= head_r + PW'(1);
      end
      // A retired redirect discards everything younger, overriding the updates above.
      if (flush_s) begin
        flush_valid <= 1'b1;
        flush_npc   <= npc_r[head_r];
        valid_r     <= {ROB_SIZE{1'b0}};
        done_r      <= {ROB_SIZE{1'b0}};
        head_r      <= {PW{1'b0}};
        tail_r      <= {PW{1'b0}};
        count_r     <= {TW{1'b0}};
      end else begin
        count_r <= count_r + {{(TW-1){1'b0}}, disp_fire_s} - {{(TW-1){1'b0}}, retire_s};
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: in-order retire scoreboard plus per-scenario checks.
module tb_rob_commit;
  localparam int ROB_SIZE = 8;
  localparam int XLEN     = 32;
  localparam int TW       = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            disp_valid = 1'b0, disp_store = 1'b0;
  logic            disp_ready;
  logic [TW-1:0]   disp_tag;
  logic [4:0]      disp_rd = 5'd0;
  logic [31:0]     disp_pc = 32'd0, disp_inst = 32'd0;
  logic            wb_valid = 1'b0, wb_pc_change = 1'b0, wb_ebreak = 1'b0;
  logic [TW-1:0]   wb_dest = '0, lk1_tag = '0, lk2_tag = '0;
  logic [31:0]     wb_result = 32'd0, wb_npc = 32'd0;
  logic            lk1_ready, lk2_ready;
  logic [31:0]     lk1_value, lk2_value;
  logic            cm_valid, cm_store, cm_ebreak, flush_valid, empty;
  logic [4:0]      cm_rd;
  logic [31:0]     cm_data, cm_pc, cm_inst, flush_npc;
  logic [TW-1:0]   cm_tag;

  typedef struct {
    logic [TW-1:0] tag;
    logic [4:0]    rd;
    logic [31:0]   data, pc, inst, npc;
    logic          st, eb, fl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   seq = 0;

  rob_commit #(.ROB_SIZE(ROB_SIZE), .XLEN(XLEN), .TW(TW)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .disp_rd(disp_rd), .disp_pc(disp_pc), .disp_inst(disp_inst), .disp_store(disp_store),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result), .wb_npc(wb_npc),
    .wb_pc_change(wb_pc_change), .wb_ebreak(wb_ebreak),
    .lk1_tag(lk1_tag), .lk2_tag(lk2_tag), .lk1_ready(lk1_ready), .lk2_ready(lk2_ready),
    .lk1_value(lk1_value), .lk2_value(lk2_value),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_data(cm_data), .cm_tag(cm_tag), .cm_pc(cm_pc),
    .cm_inst(cm_inst), .cm_store(cm_store), .cm_ebreak(cm_ebreak),
    .flush_valid(flush_valid), .flush_npc(flush_npc), .empty(empty)
  );

  always #5 clock = ~clock;

  // Retire monitor: every cm_valid pulse must match the oldest expected retirement.
  always @(negedge clock) begin
    if (!reset && cm_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: cm_valid=1 tag=%0d rd=%0d, required no retire", cm_tag, cm_rd);
      end else begin
        mon_e = exp_q.pop_front();
        if ({cm_tag, cm_rd, cm_data, cm_pc, cm_inst, cm_store, cm_ebreak, flush_valid} !==
            {mon_e.tag, mon_e.rd, mon_e.data, mon_e.pc, mon_e.inst, mon_e.st, mon_e.eb, mon_e.fl}
            || (mon_e.fl && flush_npc !== mon_e.npc)) begin
          errors++;
          $display("FAIL commit: got tag=%0d rd=%0d data=%h pc=%h inst=%h st=%b eb=%b fl=%b npc=%h, required tag=%0d rd=%0d data=%h pc=%h inst=%h st=%b eb=%b fl=%b npc=%h",
                   cm_tag, cm_rd, cm_data, cm_pc, cm_inst, cm_store, cm_ebreak, flush_valid, flush_npc,
                   mon_e.tag, mon_e.rd, mon_e.data, mon_e.pc, mon_e.inst, mon_e.st, mon_e.eb, mon_e.fl, mon_e.npc);
        end
      end
    end else if (!reset && flush_valid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL stray_flush: flush_valid=1 without cm_valid, required 0");
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    disp_valid = 1'b0; disp_store = 1'b0; wb_valid = 1'b0; wb_pc_change = 1'b0; wb_ebreak = 1'b0;
    lk1_tag = '0; lk2_tag = '0;
    cyc(); cyc();
    reset = 1'b0;
    exp_q.delete();
    seq = 0;
  endtask

  task automatic do_disp(input logic [TW-1:0] tag, input logic [4:0] rd, input logic st,
                         input logic push, input logic [31:0] data, input logic fl,
                         input logic [31:0] npc, input logic eb);
    exp_t n;
    disp_valid = 1'b1;
    disp_rd    = rd;
    disp_store = st;
    disp_pc    = 32'h0000_1000 + 32'(seq * 4);
    disp_inst  = 32'h0000_0013 | (32'(seq) << 7);
    seq++;
    n.tag = tag; n.rd = rd; n.data = data; n.pc = disp_pc; n.inst = disp_inst;
    n.st = st; n.eb = eb; n.fl = fl; n.npc = npc;
    #1;
    checks++;
    if (disp_ready !== 1'b1 || disp_tag !== tag) begin
      errors++;
      $display("FAIL dispatch: ready=%b tag=%0d, required ready=1 tag=%0d", disp_ready, disp_tag, tag);
    end
    if (push) exp_q.push_back(n);
    cyc();
    disp_valid = 1'b0;
    disp_store = 1'b0;
  endtask

  task automatic do_wb(input logic [TW-1:0] tag, input logic [31:0] data, input logic pcc,
                       input logic [31:0] npc, input logic eb);
    wb_valid = 1'b1; wb_dest = tag; wb_result = data; wb_pc_change = pcc; wb_npc = npc; wb_ebreak = eb;
    cyc();
    wb_valid = 1'b0; wb_pc_change = 1'b0; wb_ebreak = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d retirements outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({empty, disp_ready, disp_tag, cm_valid, flush_valid, cm_rd, cm_data, cm_store} !==
        {1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: empty=%b ready=%b tag=%0d cm_valid=%b flush=%b rd=%0d data=%h st=%b, required 1 1 1 0 0 0 0 0",
               empty, disp_ready, disp_tag, cm_valid, flush_valid, cm_rd, cm_data, cm_store);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    do_disp(4'd1, 5'd1, 1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 1'b0);
    do_disp(4'd2, 5'd2, 1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b0);
    do_disp(4'd3, 5'd3, 1'b0, 1'b1, 32'h30, 1'b0, 32'd0, 1'b0);
    do_wb(4'd3, 32'h30, 1'b0, 32'd0, 1'b0);
    do_wb(4'd1, 32'h10, 1'b0, 32'd0, 1'b0);
    checks++;
    if (cm_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: cm_valid=%b, required 0", cm_valid);
    end
    do_wb(4'd2, 32'h20, 1'b0, 32'd0, 1'b0);
    checks++;
    if (cm_valid !== 1'b1 || cm_rd !== 5'd1) begin
      errors++;
      $display("FAIL latency_min: cm_valid=%b rd=%0d, required 1 rd=1", cm_valid, cm_rd);
    end
    drain("in_order");
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_after_order: empty=%b, required 1", empty);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int t = 1; t <= ROB_SIZE; t++)
      do_disp(TW'(t), 5'(t), 1'b0, 1'b1, 32'h100 + 32'(t), 1'b0, 32'd0, 1'b0);
    disp_valid = 1'b1;
    #1;
    checks++;
    if (disp_ready !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: ready=%b empty=%b, required 0 0", disp_ready, empty);
    end
    cyc();
    disp_valid = 1'b0;
    do_wb(4'd1, 32'h101, 1'b0, 32'd0, 1'b0);
    checks++;
    if (disp_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_before_retire: ready=%b, required 0", disp_ready);
    end
    cyc();
    do_wb(4'd2, 32'h102, 1'b0, 32'd0, 1'b0);
    do_disp(4'd1, 5'd9, 1'b0, 1'b1, 32'h201, 1'b0, 32'd0, 1'b0);
    checks++;
    if (disp_ready !== 1'b1 || disp_tag !== 4'd2) begin
      errors++;
      $display("FAIL disp_retire_same: ready=%b tag=%0d, required 1 tag=2", disp_ready, disp_tag);
    end
    do_disp(4'd2, 5'd10, 1'b0, 1'b1, 32'h202, 1'b0, 32'd0, 1'b0);
    checks++;
    if (disp_ready !== 1'b0) begin
      errors++;
      $display("FAIL refull: ready=%b, required 0", disp_ready);
    end
    for (int t = 3; t <= ROB_SIZE; t++)
      do_wb(TW'(t), 32'h100 + 32'(t), 1'b0, 32'd0, 1'b0);
    do_wb(4'd1, 32'h201, 1'b0, 32'd0, 1'b0);
    do_wb(4'd2, 32'h202, 1'b0, 32'd0, 1'b0);
    drain("full");
  endtask

  task automatic test_flush();
    do_reset();
    for (int t = 1; t <= 5; t++)
      do_disp(TW'(t), 5'(t + 10), 1'b0, t <= 2, 32'h11 * 32'(t), t == 2, 32'h8000_0100, 1'b0);
    do_wb(4'd1, 32'h11, 1'b0, 32'd0, 1'b0);
    do_wb(4'd2, 32'h22, 1'b1, 32'h8000_0100, 1'b0);
    disp_valid = 1'b1;
    wb_valid = 1'b1; wb_dest = 4'd3; wb_result = 32'h33;
    #1;
    checks++;
    if (disp_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_disp: ready=%b, required 0", disp_ready);
    end
    cyc();
    disp_valid = 1'b0; wb_valid = 1'b0;
    lk1_tag = 4'd3;
    #1;
    checks++;
    if ({flush_valid, flush_npc, empty, disp_tag, lk1_ready} !== {1'b1, 32'h8000_0100, 1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL flush_state: flush=%b npc=%h empty=%b tag=%0d lk1_ready=%b, required 1 80000100 1 1 0",
               flush_valid, flush_npc, empty, disp_tag, lk1_ready);
    end
    cyc();
    checks++;
    if (flush_valid !== 1'b0 || cm_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_pulse: flush=%b cm_valid=%b, required 0 0", flush_valid, cm_valid);
    end
    lk1_tag = 4'd0;
    do_disp(4'd1, 5'd7, 1'b0, 1'b1, 32'h77, 1'b0, 32'd0, 1'b0);
    do_wb(4'd1, 32'h77, 1'b0, 32'd0, 1'b0);
    drain("flush");
  endtask

  task automatic test_store();
    do_reset();
    do_disp(4'd1, 5'd4, 1'b1, 1'b1, 32'h44, 1'b0, 32'd0, 1'b1);
    lk1_tag = 4'd7;
    do_wb(4'd7, 32'hBAD, 1'b0, 32'd0, 1'b0);
    cyc();
    checks++;
    if (cm_valid !== 1'b0 || lk1_ready !== 1'b0) begin
      errors++;
      $display("FAIL invalid_wb: cm_valid=%b lk1_ready=%b, required 0 0", cm_valid, lk1_ready);
    end
    do_wb(4'd1, 32'h44, 1'b0, 32'd0, 1'b1);
    cyc();
    checks++;
    if (cm_store !== 1'b1 || cm_valid !== 1'b1) begin
      errors++;
      $display("FAIL store_pulse: cm_store=%b cm_valid=%b, required 1 1", cm_store, cm_valid);
    end
    cyc();
    checks++;
    if (cm_store !== 1'b0 || cm_valid !== 1'b0) begin
      errors++;
      $display("FAIL store_once: cm_store=%b cm_valid=%b, required 0 0", cm_store, cm_valid);
    end
    lk1_tag = 4'd0;
    drain("store");
  endtask

  task automatic test_lookup();
    do_reset();
    do_disp(4'd1, 5'd5, 1'b0, 1'b1, 32'h55, 1'b0, 32'd0, 1'b0);
    do_disp(4'd2, 5'd6, 1'b0, 1'b1, 32'hDEAD, 1'b0, 32'd0, 1'b0);
    lk1_tag = 4'd2; lk2_tag = 4'd0;
    #1;
    checks++;
    if ({lk1_ready, lk2_ready, lk2_value} !== {1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL lookup_pending: lk1_ready=%b lk2_ready=%b lk2_value=%h, required 0 1 0",
               lk1_ready, lk2_ready, lk2_value);
    end
    wb_valid = 1'b1; wb_dest = 4'd2; wb_result = 32'hDEAD;
    #1;
    checks++;
`ifdef ROB_WB_BYPASS_EN
    if (lk1_ready !== 1'b1 || lk1_value !== 32'hDEAD) begin
      errors++;
      $display("FAIL lookup_bypass: ready=%b value=%h, required 1 dead", lk1_ready, lk1_value);
    end
`else
    if (lk1_ready !== 1'b0) begin
      errors++;
      $display("FAIL lookup_nobypass: ready=%b, required 0", lk1_ready);
    end
`endif
    cyc();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (lk1_ready !== 1'b1 || lk1_value !== 32'hDEAD) begin
      errors++;
      $display("FAIL lookup_stored: ready=%b value=%h, required 1 dead", lk1_ready, lk1_value);
    end
    do_wb(4'd1, 32'h55, 1'b0, 32'd0, 1'b0);
    drain("lookup");
    checks++;
    if (lk1_ready !== 1'b0) begin
      errors++;
      $display("FAIL lookup_retired: ready=%b, required 0", lk1_ready);
    end
    lk1_tag = 4'd0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int t = 1; t <= 4; t++)
      do_disp(TW'(t), 5'(t), 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    do_wb(4'd1, 32'h99, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    wb_valid = 1'b1; wb_dest = 4'd2; wb_result = 32'h98;
    cyc();
    wb_valid = 1'b0;
    reset = 1'b0;
    lk1_tag = 4'd2;
    #1;
    checks++;
    if ({empty, cm_valid, flush_valid, disp_ready, disp_tag, lk1_ready} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: empty=%b cm_valid=%b flush=%b ready=%b tag=%0d lk1_ready=%b, required 1 0 0 1 1 0",
               empty, cm_valid, flush_valid, disp_ready, disp_tag, lk1_ready);
    end
    cyc(); cyc();
    checks++;
    if (cm_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_quiet: cm_valid=%b empty=%b, required 0 1", cm_valid, empty);
    end
    lk1_tag = 4'd0;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_flush();
    test_store();
    test_lookup();
    test_reset_mid();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
